// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types and constants for the 5-stage core
package pipeline_pkg;
    typedef enum logic {RUN, MEM_WAIT} hazard_state_t;
    localparam int REG_AW = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: counts consecutive frozen memory cycles and flags the last allowed one
module hazard_wait_timer
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        r_cnt <= (!rst_n || clear) ? '0 : run ? r_cnt + 1'b1 : r_cnt;
    end
    assign expired = (r_cnt == LAST);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline stall/flush/PC-enable sequencing for load-use, redirect and dmem wait.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_events counters.
module hazard_ctrl_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = pipeline_pkg::REG_AW,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs2,
    input  logic              id_ex_memRead,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              ex_redirect,
    input  logic              ex_mem_memAccess,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_flush,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);
    hazard_state_t r_state, w_next;
    logic w_wait_req, w_expired, w_timeout, w_freeze, w_load_use;
    assign w_wait_req = (r_state == RUN) ? (ex_mem_memAccess && !dmem_ready) : !dmem_ready;
    assign w_timeout  = (r_state == MEM_WAIT) && w_wait_req && w_expired;
    assign w_freeze   = w_wait_req && !w_timeout;
    assign w_load_use = id_ex_memRead && (id_ex_rd != '0) &&
                        (id_ex_rd == if_id_rs1 || (if_id_use_rs2 && id_ex_rd == if_id_rs2));
    hazard_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_freeze),
        .clear   (!w_freeze),
        .expired (w_expired)
    );
    always_ff @(posedge clk) begin
        r_state <= rst_n ? w_next : RUN;
    end
    always_comb begin
        w_next       = w_freeze ? MEM_WAIT : RUN;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        mem_timeout  = rst_n && w_timeout;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (w_freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            // squashing the consumer makes any coincident load-use moot
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(!pc_en);
            r_flush_events <= r_flush_events + CNT_W'(id_ex_flush);
        end
    end
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; companion to the operand forwarding logic in EX.
- Handles the hazards forwarding cannot resolve: load-use bubbles, taken-branch/jump squash, and a multi-cycle data-memory wait with timeout.
- Drives the stage-register enables and flushes plus the PC write enable.

Parameters:
- REG_AW, 5, register index width.
- MEM_TIMEOUT, 16, max cycles held in MEM_WAIT before abort (>=2).
- CNT_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- if_id_rs1  in  REG_AW  ID-stage source 1 index
- if_id_rs2  in  REG_AW  ID-stage source 2 index
- if_id_use_rs2  in  1  ID instruction reads rs2 (R-type/store/branch)
- id_ex_memRead  in  1  EX-stage instruction is a load
- id_ex_rd  in  REG_AW  EX-stage destination
- ex_redirect  in  1  taken branch/jump resolved in EX
- ex_mem_memAccess  in  1  MEM-stage load/store active
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC register write enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX load NOP
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_flush  out  1  MEM/WB load NOP
- mem_timeout  out  1  one-cycle abort pulse
- stall_cycles  out  CNT_W  perf counter
- flush_events  out  CNT_W  perf counter

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered state, 0-cycle decode of outputs from state plus inputs.
- Reset (rst_n=0 at posedge): state=RUN, wait counter=0, counters=0. While rst_n=0, outputs are forced: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1, mem_timeout=0.
- Default (no hazard): all enables 1, all flushes 0.
- Priority, highest first: memory wait > redirect > load-use.
- Memory wait (RUN with ex_mem_memAccess=1 and dmem_ready=0, or any MEM_WAIT cycle with dmem_ready=0):
  - pc_en, if_id_en, id_ex_en, ex_mem_en all 0; mem_wb_flush=1.
  - Redirect and load-use are ignored; their inputs stay stable while frozen.
  - RUN -> MEM_WAIT at the clock edge.
- MEM_WAIT:
  - Wait counter increments each cycle.
  - dmem_ready=1: outputs as RUN for that cycle; ->RUN; counter cleared.
  - Counter reaches MEM_TIMEOUT-1 with dmem_ready=0: mem_timeout=1 that cycle, outputs as dmem_ready=1 (access dropped, pipeline advances); ->RUN.
  - Reset mid-wait returns to RUN with no timeout pulse.
- Redirect (ex_redirect=1, no memory wait): pc_en=1 (target loads), if_id_flush=1, id_ex_flush=1. A coincident load-use condition is suppressed because the consumer is squashed.
- Load-use (id_ex_memRead=1, id_ex_rd!=0, and id_ex_rd==if_id_rs1 or (if_id_use_rs2 and id_ex_rd==if_id_rs2)): pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle. The condition self-clears once the load advances. rd=x0 never stalls.
- ex_redirect, id_ex_memRead, and if_id_* are qualified by valid upstream; the unit does not re-check validity.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro:
  - stall_cycles increments on every cycle with pc_en=0 and rst_n=1.
  - flush_events increments on each cycle with id_ex_flush=1 and rst_n=1.
  - Both counters wrap at 2^CNT_W.
- Without the macro: both ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Shared package pipeline_pkg holds:
  - hazard_state_t enum (RUN, MEM_WAIT).
  - REG_AW.
  - The NOP-encoding constant already used by the stage registers.
- One sub-module is natural: hazard_wait_timer, which provides the MEM_WAIT counter and timeout compare (inputs: clk, rst_n, run, clear; output: expired).

Test Plan:
- Load-use: lw x5 in EX (id_ex_memRead=1, id_ex_rd=5), ID rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- x0 and I-type: id_ex_rd=0 with rs1=0 -> no stall. id_ex_rd=7, rs2=7, if_id_use_rs2=0 -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
- Memory wait: ex_mem_memAccess=1, dmem_ready low for 3 cycles -> 3 frozen cycles with mem_wb_flush=1; on ready, resume; redirect asserted during the freeze is acted on only after release.
- Timeout: dmem_ready held 0 with MEM_TIMEOUT=16 -> mem_timeout=1 on the 16th stalled cycle, state RUN next. Repeat with rst_n=0 in cycle 5 -> RUN, no pulse, reset output values.
- With HAZARD_PERF_CNT_EN: after the scenarios above, stall_cycles and flush_events equal the bench-counted totals. Without the macro, both read 0.
